// File: rtl/choreo_sequencer_if.sv
// Bundle between config/user logic and choreo_sequencer: show controls,
// playlist write port, pattern-generator drive and status.
// skip exists only when CHOREO_SKIP_EN is defined.
interface choreo_sequencer_if #(
  parameter int AW = 3,
  parameter int DW = 6
);
  // show control and time base
  logic          tick;
  logic          start;
  logic          stop;
  logic          hold;
  logic          loop;
  logic [AW:0]   len;
`ifdef CHOREO_SKIP_EN
  logic          skip;
`endif
  // playlist write port: {pattern[2:0], speed, dwell}
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW+3:0] wr_data;
  // generator drive and status
  logic [2:0]    pat_sel;
  logic          speed_sel;
  logic          pause;
  logic          ena;
  logic          busy;
  logic [AW-1:0] step_idx;
  logic          done;

  modport master (
`ifdef CHOREO_SKIP_EN
    output skip,
`endif
    output tick, start, stop, hold, loop, len, wr_en, wr_addr, wr_data,
    input  pat_sel, speed_sel, pause, ena, busy, step_idx, done
  );

  modport slave (
`ifdef CHOREO_SKIP_EN
    input  skip,
`endif
    input  tick, start, stop, hold, loop, len, wr_en, wr_addr, wr_data,
    output pat_sel, speed_sel, pause, ena, busy, step_idx, done
  );
endinterface

// File: rtl/choreo_sequencer.sv
// Playlist sequencer for the 8-LED pattern generator: plays table entries
// {pattern, speed, dwell} for dwell ticks each, one-shot or looping, with hold/stop.
// Optional feature macro: CHOREO_SKIP_EN (adds the skip pulse that ends an entry early).
module choreo_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  choreo_sequencer_if.slave bus
);

  localparam int          EW      = DW + 4;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    pat_sel_q, pat_sel_d;
  logic          speed_sel_q, speed_sel_d;
  logic          pause_q, pause_d;
  logic          ena_q, ena_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [AW-1:0] step_idx_q, step_idx_d;
  logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [AW:0]   len_q, len_d;

  logic [EW-1:0] table_q [DEPTH];
  logic [EW-1:0] entry;
  logic [2:0]    ent_pat;
  logic          ent_speed;
  logic [DW-1:0] ent_dwell;
  logic          last_entry;
  logic          entry_end;
  logic          to_idle;

  // Playlist storage; not reset so a show can be replayed after rst.
  always_ff @(posedge clk) begin
    if (bus.wr_en) table_q[bus.wr_addr] <= bus.wr_data;
  end

  assign entry     = table_q[step_idx_q];
  assign ent_pat   = entry[EW-1:EW-3];
  assign ent_speed = entry[DW];
  assign ent_dwell = entry[DW-1:0];

  assign last_entry = ({1'b0, step_idx_q} == (len_q - LEN_ONE));

`ifdef CHOREO_SKIP_EN
  assign entry_end = bus.skip | (bus.tick & (dwell_cnt_q == DW'(1)));
`else
  assign entry_end = bus.tick & (dwell_cnt_q == DW'(1));
`endif

  // Next-state and registered-output logic; stop > hold > tick/skip.
  always_comb begin
    state_d     = state_q;
    pat_sel_d   = pat_sel_q;
    speed_sel_d = speed_sel_q;
    pause_d     = pause_q;
    ena_d       = ena_q;
    done_d      = 1'b0;
    step_idx_d  = step_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    len_d       = len_q;
    to_idle     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop && (bus.len != '0)) begin
          len_d      = (bus.len > DEPTH_V) ? DEPTH_V : bus.len;
          step_idx_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          to_idle = 1'b1;
        end else begin
          // The entry is fetched even when hold arrives here, so the
          // remaining dwell is ready when the hold is released.
          pat_sel_d   = ent_pat;
          speed_sel_d = ent_speed;
          dwell_cnt_d = (ent_dwell == '0) ? DW'(1) : ent_dwell;
          ena_d       = 1'b1;
          pause_d     = bus.hold;
          state_d     = bus.hold ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          to_idle = 1'b1;
        end else if (bus.hold) begin
          pause_d = 1'b1;
          state_d = S_HOLD;
        end else if (entry_end) begin
          dwell_cnt_d = '0;
          if (!last_entry) begin
            step_idx_d = step_idx_q + AW'(1);
            state_d    = S_LOAD;
          end else if (bus.loop) begin
            step_idx_d = '0;
            state_d    = S_LOAD;
          end else begin
            to_idle = 1'b1;
            done_d  = 1'b1;
          end
        end else if (bus.tick) begin
          dwell_cnt_d = dwell_cnt_q - DW'(1);
        end
      end
      S_HOLD: begin
        if (bus.stop) begin
          to_idle = 1'b1;
        end else if (!bus.hold) begin
          pause_d = 1'b0;
          state_d = S_RUN;
        end
      end
      default: to_idle = 1'b1;
    endcase

    // Returning to IDLE restores the reset-time outputs; len_q is left as is.
    if (to_idle) begin
      state_d     = S_IDLE;
      pat_sel_d   = 3'b111;
      speed_sel_d = 1'b0;
      pause_d     = 1'b1;
      ena_d       = 1'b0;
      step_idx_d  = '0;
      dwell_cnt_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pat_sel_q   <= 3'b111;
      speed_sel_q <= 1'b0;
      pause_q     <= 1'b1;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      pat_sel_q   <= pat_sel_d;
      speed_sel_q <= speed_sel_d;
      pause_q     <= pause_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_idx_q  <= step_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      len_q       <= len_d;
    end
  end

  assign bus.pat_sel   = pat_sel_q;
  assign bus.speed_sel = speed_sel_q;
  assign bus.pause     = pause_q;
  assign bus.ena       = ena_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_idx  = step_idx_q;

endmodule

// File: tb/tb_choreo_sequencer.sv
// Bench for choreo_sequencer: directed show scenarios plus randomized playlists
// checked against a playlist-level model (each entry = max(dwell,1) ticks, in order).
`timescale 1ns/1ps
module tb_choreo_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  choreo_sequencer_if #(.AW(AW), .DW(DW)) bus ();

  choreo_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // One observed playlist segment: which entry, what it showed, ticks it consumed.
  typedef struct {
    int         step;
    logic [3:0] ps;
    int         ticks;
  } seg_t;
  seg_t segs[$];
  int   ndone;
  bit   timed_out;

  // Model copy of the playlist table.
  logic [2:0] m_pat  [DEPTH];
  logic       m_spd  [DEPTH];
  int         m_dwell[DEPTH];

  function automatic int eff_dwell(input int e);
    return (m_dwell[e] == 0) ? 1 : m_dwell[e];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.hold = 0; bus.loop = 0;
    bus.len = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef CHOREO_SKIP_EN
    bus.skip = 0;
`endif
  endtask

  task automatic wr(input int a, input logic [2:0] p, input logic s, input int d);
    bus.wr_en   = 1;
    bus.wr_addr = AW'(a);
    bus.wr_data = {p, s, DW'(d)};
    cyc();
    bus.wr_en   = 0;
    m_pat[a] = p; m_spd[a] = s; m_dwell[a] = d;
  endtask

  task automatic load_demo();
    wr(0, 3'b000, 1'b0, 2);
    wr(1, 3'b010, 1'b1, 3);
    wr(2, 3'b101, 1'b0, 1);
  endtask

  // Start a show and record segments until it ends or max_segs complete.
  // period>0: tick every period cycles; period==0: random gaps (never in a LOAD cycle).
  task automatic run_show(input int period, input int max_segs);
    int gap; int cur; bit fin;
    segs.delete(); ndone = 0; timed_out = 0; cur = -1; fin = 0; gap = 2;
    bus.start = 1; cyc(); bus.start = 0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      if (period > 0) bus.tick = (c % period == period - 1);
      else begin
        bus.tick = (gap == 0);
        gap = (gap == 0) ? int'($urandom_range(1, 4)) : gap - 1;
      end
      @(negedge clk);
      if (bus.busy) begin
        if (int'(bus.step_idx) != cur) begin
          if (segs.size() == max_segs) fin = 1;
          else begin
            seg_t s;
            s.step = int'(bus.step_idx); s.ps = 4'bxxxx; s.ticks = 0;
            segs.push_back(s);
            cur = int'(bus.step_idx);
          end
        end
        if (!fin && bus.tick) begin
          segs[$].ticks++;
          segs[$].ps = {bus.pat_sel, bus.speed_sel};
        end
      end else fin = 1;
      if (bus.done) ndone++;
      cyc();
    end
    bus.tick = 0;
    if (!fin) timed_out = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; cyc(); cyc(); rst = 0;
    @(negedge clk);
    n_total++;
    if ({bus.pat_sel, bus.speed_sel, bus.pause, bus.ena, bus.busy, bus.step_idx, bus.done} !== {3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0})
      $display("FAIL reset got pat=%b spd=%b pause=%b ena=%b busy=%b step=%0d done=%b want 111 0 1 0 0 0 0",
               bus.pat_sel, bus.speed_sel, bus.pause, bus.ena, bus.busy, bus.step_idx, bus.done);
    else n_pass++;
    // start with len==0 is ignored
    cyc();
    bus.len = '0; bus.start = 1; cyc(); bus.start = 0; cyc();
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL len_zero busy=%b want 0", bus.busy);
    else n_pass++;
    cyc();
  endtask

  task automatic test_one_shot();
    load_demo();
    bus.len = 3; bus.loop = 0;
    run_show(4, 100);
    n_total++;
    if (timed_out || segs.size() != 3) $display("FAIL one_shot_segs got %0d (timeout=%0d) want 3", segs.size(), timed_out);
    else n_pass++;
    for (int i = 0; i < segs.size(); i++) begin
      int e; e = i;
      n_total++;
      if (segs[i].step !== e || segs[i].ticks !== eff_dwell(e) || segs[i].ps !== {m_pat[e], m_spd[e]})
        $display("FAIL one_shot_seg%0d got step=%0d ticks=%0d ps=%b want step=%0d ticks=%0d ps=%b",
                 i, segs[i].step, segs[i].ticks, segs[i].ps, e, eff_dwell(e), {m_pat[e], m_spd[e]});
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (ndone != 1 || bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.pat_sel !== 3'b111 || bus.ena !== 1'b0 || bus.pause !== 1'b1)
      $display("FAIL one_shot_end got ndone=%0d done=%b busy=%b pat=%b ena=%b pause=%b want 1 0 0 111 0 1",
               ndone, bus.done, bus.busy, bus.pat_sel, bus.ena, bus.pause);
    else n_pass++;
    cyc();
  endtask

  task automatic test_latency();
    bus.len = 3; bus.start = 1; cyc(); bus.start = 0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b1 || bus.pat_sel !== 3'b111)
      $display("FAIL latency_load got busy=%b pat=%b want 1 111", bus.busy, bus.pat_sel);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== m_pat[0] || bus.ena !== 1'b1 || bus.pause !== 1'b0)
      $display("FAIL latency_out got pat=%b ena=%b pause=%b want %b 1 0", bus.pat_sel, bus.ena, bus.pause, m_pat[0]);
    else n_pass++;
    bus.stop = 1; cyc(); bus.stop = 0; cyc();
  endtask

  task automatic test_loop();
    bus.len = 3; bus.loop = 1;
    run_show(4, 9);
    n_total++;
    if (timed_out || segs.size() != 9 || ndone != 0)
      $display("FAIL loop_laps got segs=%0d done_pulses=%0d timeout=%0d want 9 0", segs.size(), ndone, timed_out);
    else n_pass++;
    for (int i = 0; i < segs.size(); i++) begin
      int e; e = i % 3;
      n_total++;
      if (segs[i].step !== e || segs[i].ticks !== eff_dwell(e) || segs[i].ps !== {m_pat[e], m_spd[e]})
        $display("FAIL loop_seg%0d got step=%0d ticks=%0d ps=%b want step=%0d ticks=%0d ps=%b",
                 i, segs[i].step, segs[i].ticks, segs[i].ps, e, eff_dwell(e), {m_pat[e], m_spd[e]});
      else n_pass++;
    end
    bus.stop = 1; cyc(); bus.stop = 0; bus.loop = 0;
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL loop_stop got busy=%b done=%b want 0 0", bus.busy, bus.done);
    else n_pass++;
    cyc();
  endtask

  task automatic test_hold();
    int t1, post, hs; bit bad, got2; logic rel_pause;
    t1 = 0; post = 0; hs = -1; bad = 0; got2 = 0; rel_pause = 1'bx;
    bus.len = 3; bus.loop = 0; bus.start = 1; cyc(); bus.start = 0;
    for (int c = 0; c < 200 && !got2; c++) begin
      bus.tick = (c % 4 == 3);
      if (hs < 0 && t1 == 1 && c % 4 == 0) hs = c;
      bus.hold = (hs >= 0 && c >= hs && c < hs + 20);
      @(negedge clk);
      if (hs >= 0 && c > hs && c < hs + 20 && (bus.pause !== 1'b1 || bus.pat_sel !== 3'b010 || bus.step_idx !== 3'd1)) bad = 1;
      if (hs >= 0 && c == hs + 21) rel_pause = bus.pause;
      if (bus.step_idx == 3'd1 && bus.tick && !bus.hold) begin
        if (hs < 0) t1++;
        else if (c >= hs + 20) post++;
      end
      if (bus.step_idx == 3'd2) got2 = 1;
      cyc();
    end
    bus.tick = 0; bus.hold = 0;
    n_total++;
    if (!got2 || bad || rel_pause !== 1'b0)
      $display("FAIL hold_freeze got reached_entry2=%0d bad_during_hold=%0d pause_after_release=%b want 1 0 0", got2, bad, rel_pause);
    else n_pass++;
    n_total++;
    if (post != 2) $display("FAIL hold_remaining got %0d ticks after release want 2", post);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== 3'b101) $display("FAIL hold_next got pat=%b want 101", bus.pat_sel);
    else n_pass++;
    bus.stop = 1; cyc(); bus.stop = 0; cyc();
  endtask

  task automatic test_stop_start();
    bus.len = 3; bus.loop = 0; bus.start = 1; cyc(); bus.start = 0;
    for (int c = 0; c < 10; c++) begin
      bus.tick = (c % 4 == 3);
      cyc();
    end
    bus.tick = 0;
    @(negedge clk);
    n_total++;
    if (bus.step_idx !== 3'd1) $display("FAIL stop_pre got step=%0d want 1", bus.step_idx);
    else n_pass++;
    bus.stop = 1; bus.start = 1; cyc(); bus.stop = 0; bus.start = 0;
    @(negedge clk);
    n_total++;
    if ({bus.pat_sel, bus.step_idx, bus.done, bus.busy, bus.ena, bus.pause} !== {3'b111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL stop_start got pat=%b step=%0d done=%b busy=%b ena=%b pause=%b want 111 0 0 0 0 1",
               bus.pat_sel, bus.step_idx, bus.done, bus.busy, bus.ena, bus.pause);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL stop_stays_idle busy=%b want 0", bus.busy);
    else n_pass++;
    cyc();
  endtask

  task automatic test_write_live();
    wr(0, 3'b001, 1'b0, 2);
    bus.len = 1; bus.loop = 1; bus.start = 1; cyc(); bus.start = 0;
    cyc(); cyc();
    wr(0, 3'b110, 1'b1, 1);
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== 3'b001 || bus.speed_sel !== 1'b0)
      $display("FAIL write_live_hold got pat=%b spd=%b want 001 0", bus.pat_sel, bus.speed_sel);
    else n_pass++;
    bus.tick = 1; cyc(); bus.tick = 0; cyc();
    bus.tick = 1; cyc(); bus.tick = 0; cyc();
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== 3'b110 || bus.speed_sel !== 1'b1 || bus.step_idx !== 3'd0)
      $display("FAIL write_live_reload got pat=%b spd=%b step=%0d want 110 1 0", bus.pat_sel, bus.speed_sel, bus.step_idx);
    else n_pass++;
    bus.stop = 1; cyc(); bus.stop = 0; bus.loop = 0; cyc();
  endtask

  task automatic test_dwell_zero();
    wr(0, 3'b011, 1'b1, 0);
    wr(1, 3'b100, 1'b0, 0);
    bus.len = 2; bus.loop = 0;
    run_show(0, 100);
    n_total++;
    if (timed_out || segs.size() != 2 || ndone != 1)
      $display("FAIL dwell_zero got segs=%0d done_pulses=%0d timeout=%0d want 2 1", segs.size(), ndone, timed_out);
    else n_pass++;
    for (int i = 0; i < segs.size(); i++) begin
      n_total++;
      if (segs[i].ticks !== 1 || segs[i].ps !== {m_pat[i], m_spd[i]})
        $display("FAIL dwell_zero_seg%0d got ticks=%0d ps=%b want 1 %b", i, segs[i].ticks, segs[i].ps, {m_pat[i], m_spd[i]});
      else n_pass++;
    end
    cyc();
  endtask

`ifdef CHOREO_SKIP_EN
  task automatic test_skip();
    load_demo();
    bus.len = 3; bus.loop = 0; bus.start = 1; cyc(); bus.start = 0;
    cyc();
    bus.skip = 1; cyc(); bus.skip = 0;
    @(negedge clk);
    n_total++;
    if (bus.step_idx !== 3'd1 || bus.pat_sel !== 3'b000)
      $display("FAIL skip_load got step=%0d pat=%b want 1 000", bus.step_idx, bus.pat_sel);
    else n_pass++;
    cyc();
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== 3'b010 || bus.speed_sel !== 1'b1)
      $display("FAIL skip_next got pat=%b spd=%b want 010 1", bus.pat_sel, bus.speed_sel);
    else n_pass++;
    bus.stop = 1; cyc(); bus.stop = 0; cyc();
  endtask
`endif

  task automatic test_rst_mid();
    load_demo();
    bus.len = 3; bus.start = 1; cyc(); bus.start = 0;
    cyc(); cyc();
    rst = 1; cyc(); rst = 0;
    @(negedge clk);
    n_total++;
    if ({bus.pat_sel, bus.pause, bus.ena, bus.busy, bus.step_idx} !== {3'b111, 1'b1, 1'b0, 1'b0, 3'd0})
      $display("FAIL rst_mid got pat=%b pause=%b ena=%b busy=%b step=%0d want 111 1 0 0 0",
               bus.pat_sel, bus.pause, bus.ena, bus.busy, bus.step_idx);
    else n_pass++;
    // table survives reset: replay entry 0 without rewriting
    wr(0, 3'b110, 1'b0, 2);
    rst = 1; cyc(); rst = 0;
    bus.start = 1; cyc(); bus.start = 0; cyc();
    @(negedge clk);
    n_total++;
    if (bus.pat_sel !== 3'b110) $display("FAIL rst_table_kept got pat=%b want 110", bus.pat_sel);
    else n_pass++;
    bus.stop = 1; cyc(); bus.stop = 0; cyc();
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int lenv, nexp, bad_seg;
      for (int a = 0; a < DEPTH; a++)
        wr(a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, (r == 1) ? 20 : 7)));
      lenv = (r == 0) ? 15 : int'($urandom_range(1, 15));
      nexp = (lenv > DEPTH) ? DEPTH : lenv;
      bus.len = (AW+1)'(lenv); bus.loop = 0;
      run_show(0, 100);
      n_total++;
      if (timed_out || segs.size() != nexp || ndone != 1)
        $display("FAIL random%0d_len got segs=%0d done_pulses=%0d timeout=%0d want %0d 1", r, segs.size(), ndone, timed_out, nexp);
      else n_pass++;
      bad_seg = -1;
      for (int i = 0; i < segs.size(); i++)
        if (bad_seg < 0 && (segs[i].step !== i || segs[i].ticks !== eff_dwell(i) || segs[i].ps !== {m_pat[i], m_spd[i]}))
          bad_seg = i;
      n_total++;
      if (bad_seg >= 0)
        $display("FAIL random%0d_seg%0d got step=%0d ticks=%0d ps=%b want step=%0d ticks=%0d ps=%b", r, bad_seg,
                 segs[bad_seg].step, segs[bad_seg].ticks, segs[bad_seg].ps, bad_seg, eff_dwell(bad_seg), {m_pat[bad_seg], m_spd[bad_seg]});
      else n_pass++;
      cyc();
    end
  endtask

  initial begin
    rst = 1;
    test_reset();
    test_one_shot();
    test_latency();
    test_loop();
    test_hold();
    test_stop_start();
    test_write_live();
    test_dwell_zero();
`ifdef CHOREO_SKIP_EN
    test_skip();
`endif
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
